// File: rtl/axi_pkg.sv
// Shared AXI4 write-channel types and arbiter state encoding.
// Used by axi_wr_arbiter and axi_write.
package axi_pkg;

  localparam logic       LO        = 1'b0;
  localparam logic       HI        = 1'b1;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // 56-bit write-address channel, valid in the LSB
  typedef struct packed {
    logic        id;
    logic [28:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic        valid;
  } axi_aw_t;

  // 38-bit write-data channel
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic        valid;
  } axi_w_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AWCH,
    ST_WCH,
    ST_BCH
  } arb_state_t;

endpackage

// File: rtl/axi_wr_arbiter.sv
// Two-requester round-robin arbiter for one AXI4 write port, one transaction in flight.
// Checks WLAST against AWLEN and counts non-OKAY write responses.
module axi_wr_arbiter
  import axi_pkg::*;
#(
  parameter int LEN_W     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  axi_aw_t              m0_aw_i,
  output logic                 m0_awready_o,
  input  axi_w_t               m0_w_i,
  output logic                 m0_wready_o,
  input  logic                 m0_bready_i,
  output logic                 m0_bvalid_o,
  output logic [1:0]           m0_bresp_o,
  input  axi_aw_t              m1_aw_i,
  output logic                 m1_awready_o,
  input  axi_w_t               m1_w_i,
  output logic                 m1_wready_o,
  input  logic                 m1_bready_i,
  output logic                 m1_bvalid_o,
  output logic [1:0]           m1_bresp_o,
  output axi_aw_t              s_aw_o,
  input  logic                 s_awready_i,
  output axi_w_t               s_w_o,
  input  logic                 s_wready_i,
  input  logic                 s_bvalid_i,
  input  logic [1:0]           s_bresp_i,
  output logic                 s_bready_o,
  output logic [1:0]           grant_o,
  output logic                 busy_o,
  output logic                 len_err_o,
  output logic [ERR_CNT_W-1:0] resp_err_cnt_o
);

  axi_aw_t    aw_in [2];
  axi_w_t     w_in  [2];
  logic [1:0] bready_in;
  logic [1:0] awready_out, wready_out, bvalid_out;
  logic [1:0] bresp_out [2];

  assign aw_in[0]  = m0_aw_i;
  assign aw_in[1]  = m1_aw_i;
  assign w_in[0]   = m0_w_i;
  assign w_in[1]   = m1_w_i;
  assign bready_in = {m1_bready_i, m0_bready_i};

  assign m0_awready_o = awready_out[0];
  assign m1_awready_o = awready_out[1];
  assign m0_wready_o  = wready_out[0];
  assign m1_wready_o  = wready_out[1];
  assign m0_bvalid_o  = bvalid_out[0];
  assign m1_bvalid_o  = bvalid_out[1];
  assign m0_bresp_o   = bresp_out[0];
  assign m1_bresp_o   = bresp_out[1];

  arb_state_t           state_reg, state_next;
  logic                 grant_reg, grant_next;
  logic                 last_g_reg;
  logic [LEN_W-1:0]     len_reg, beat_cnt_reg;
  logic                 len_err_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;
  logic                 aw_hs, w_hs, b_hs;

  assign aw_hs = (state_reg == ST_AWCH) && aw_in[grant_reg].valid && s_awready_i;
  assign w_hs  = (state_reg == ST_WCH)  && w_in[grant_reg].valid  && s_wready_i;
  assign b_hs  = (state_reg == ST_BCH)  && s_bvalid_i && bready_in[grant_reg];

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      grant_reg <= LO;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
    end
  end

  // Grant is chosen once in IDLE and frozen until the B handshake
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    case (state_reg)
      ST_IDLE: begin
        if (aw_in[0].valid && aw_in[1].valid) begin
          grant_next = ~last_g_reg;
          state_next = ST_AWCH;
        end else if (aw_in[0].valid) begin
          grant_next = LO;
          state_next = ST_AWCH;
        end else if (aw_in[1].valid) begin
          grant_next = HI;
          state_next = ST_AWCH;
        end
      end
      ST_AWCH: if (aw_hs) state_next = ST_WCH;
      ST_WCH:  if (w_hs && w_in[grant_reg].last) state_next = ST_BCH;
      ST_BCH:  if (b_hs) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_aw_o     = '0;
    s_w_o      = '0;
    s_bready_o = LO;
    case (state_reg)
      ST_AWCH: s_aw_o     = aw_in[grant_reg];
      ST_WCH:  s_w_o      = w_in[grant_reg];
      ST_BCH:  s_bready_o = bready_in[grant_reg];
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic sel;
      assign sel             = (grant_reg == 1'(gi));
      assign awready_out[gi] = sel && (state_reg == ST_AWCH) && s_awready_i;
      assign wready_out[gi]  = sel && (state_reg == ST_WCH)  && s_wready_i;
      assign bvalid_out[gi]  = sel && (state_reg == ST_BCH)  && s_bvalid_i;
      assign bresp_out[gi]   = (sel && (state_reg == ST_BCH)) ? s_bresp_i : RESP_OKAY;
    end
  endgenerate

  // beat_cnt holds the beats accepted before the current one, so the final beat sees cnt == len
  always_ff @(posedge clk_i) begin
    if (rst) begin
      last_g_reg   <= HI;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      len_err_reg  <= LO;
      err_cnt_reg  <= '0;
    end else begin
      if (aw_hs) begin
        len_reg      <= LEN_W'(aw_in[grant_reg].len);
        beat_cnt_reg <= '0;
      end
      if (w_hs) begin
        beat_cnt_reg <= beat_cnt_reg + LEN_W'(1);
        if ((w_in[grant_reg].last && (beat_cnt_reg != len_reg)) ||
            (!w_in[grant_reg].last && (beat_cnt_reg == len_reg)))
          len_err_reg <= HI;
      end
      if (b_hs) begin
        last_g_reg <= grant_reg;
        if ((s_bresp_i != RESP_OKAY) && (err_cnt_reg != '1))
          err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
      end
    end
  end

  assign grant_o        = (state_reg == ST_IDLE) ? 2'b00 : (grant_reg ? 2'b10 : 2'b01);
  assign busy_o         = (state_reg != ST_IDLE);
  assign len_err_o      = len_err_reg;
  assign resp_err_cnt_o = err_cnt_reg;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed + randomized bench for axi_wr_arbiter; the bench plays both requesters and the slave.
// Expected grants, counters and flags come from a transaction-level model of the arbitration rules.
module tb_axi_wr_arbiter;
  import axi_pkg::*;

  localparam int LEN_W     = 8;
  localparam int ERR_CNT_W = 8;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  axi_aw_t    aw_drv [2];
  axi_w_t     w_drv  [2];
  logic [1:0] bready_drv;
  wire  [1:0] awready_obs, wready_obs, bvalid_obs;
  wire  [3:0] bresp_obs;

  axi_aw_t              s_aw_o;
  axi_w_t               s_w_o;
  logic                 s_awready_i, s_wready_i, s_bvalid_i;
  logic [1:0]           s_bresp_i;
  logic                 s_bready_o;
  logic [1:0]           grant_o;
  logic                 busy_o, len_err_o;
  logic [ERR_CNT_W-1:0] resp_err_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  // transaction-level model
  bit model_last_g;
  int model_cnt;
  bit model_len_err;
  bit pending  [2];
  int pend_len [2];

  always #5 clk = ~clk;

  axi_wr_arbiter #(.LEN_W(LEN_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk_i(clk), .rst(rst),
    .m0_aw_i(aw_drv[0]), .m0_awready_o(awready_obs[0]), .m0_w_i(w_drv[0]),
    .m0_wready_o(wready_obs[0]), .m0_bready_i(bready_drv[0]),
    .m0_bvalid_o(bvalid_obs[0]), .m0_bresp_o(bresp_obs[1:0]),
    .m1_aw_i(aw_drv[1]), .m1_awready_o(awready_obs[1]), .m1_w_i(w_drv[1]),
    .m1_wready_o(wready_obs[1]), .m1_bready_i(bready_drv[1]),
    .m1_bvalid_o(bvalid_obs[1]), .m1_bresp_o(bresp_obs[3:2]),
    .s_aw_o(s_aw_o), .s_awready_i(s_awready_i), .s_w_o(s_w_o), .s_wready_i(s_wready_i),
    .s_bvalid_i(s_bvalid_i), .s_bresp_i(s_bresp_i), .s_bready_o(s_bready_o),
    .grant_o(grant_o), .busy_o(busy_o), .len_err_o(len_err_o),
    .resp_err_cnt_o(resp_err_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] onehot(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic axi_w_t mk_beat(input int idx, input int lastpos);
    axi_w_t b;
    b.data  = $urandom;
    b.strb  = 4'($urandom);
    b.last  = (idx == lastpos);
    b.valid = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    model_last_g  = 1'b1;
    model_cnt     = 0;
    model_len_err = 1'b0;
    pending[0]    = 1'b0;
    pending[1]    = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic post_aw(input int m, input int len);
    logic [63:0] r;
    r = {$urandom, $urandom};
    aw_drv[m]       = axi_aw_t'(r[55:0]);
    aw_drv[m].len   = 8'(len);
    aw_drv[m].valid = 1'b1;
    pending[m]      = 1'b1;
    pend_len[m]     = len;
  endtask

  task automatic check_all_quiet(input string tag);
    chk({tag, "_s_aw"},    64'(s_aw_o), 64'd0);
    chk({tag, "_s_w"},     64'(s_w_o), 64'd0);
    chk({tag, "_s_bready"}, 64'(s_bready_o), 64'd0);
    chk({tag, "_rdy_bv"},  64'({awready_obs, wready_obs, bvalid_obs}), 64'd0);
    chk({tag, "_grant"},   64'(grant_o), 64'd0);
    chk({tag, "_busy"},    64'(busy_o), 64'd0);
    chk({tag, "_len_err"}, 64'(len_err_o), 64'd0);
    chk({tag, "_cnt"},     64'(resp_err_cnt_o), 64'd0);
  endtask

  // One whole transaction for the requester the model says should win.
  // lastpos_in < 0 puts WLAST where AWLEN says; abort_at > 0 pulses rst after that many beats.
  task automatic serve_one(input int lastpos_in, input logic [1:0] bresp, input int awdelay,
                           input int wmode, input int abort_at);
    int win, los, cyc, fwd, lastpos, d;
    bit done, acc;
    win     = (pending[0] && pending[1]) ? (model_last_g ? 0 : 1) : (pending[0] ? 0 : 1);
    los     = 1 - win;
    lastpos = (lastpos_in < 0) ? pend_len[win] : lastpos_in;

    cyc = 0;
    #1;
    while (grant_o === 2'b00 && cyc < 8) begin
      chk("idle_s_aw", 64'(s_aw_o), 64'd0);
      chk("idle_awready", 64'(awready_obs), 64'd0);
      tick();
      #1;
      cyc++;
    end
    chk("grant", 64'(grant_o), 64'(onehot(win)));
    chk("busy", 64'(busy_o), 64'd1);

    // W beat offered before AW acceptance must not leak through
    w_drv[win] = mk_beat(0, lastpos);
    for (cyc = 0; cyc < 64; cyc++) begin
      s_awready_i = (cyc >= awdelay);
      #1;
      chk("s_aw", 64'(s_aw_o), 64'(aw_drv[win]));
      chk("awready_win", 64'(awready_obs[win]), 64'(s_awready_i));
      chk("awready_los", 64'(awready_obs[los]), 64'd0);
      chk("w_blocked", 64'({wready_obs, s_w_o}), 64'd0);
      if (s_awready_i) break;
      tick();
    end
    tick();
    s_awready_i = 1'b0;
    aw_drv[win] = '0;
    pending[win] = 1'b0;

    fwd  = 0;
    done = 1'b0;
    for (cyc = 0; cyc < 4000 && !done; cyc++) begin
      case (wmode)
        0:       s_wready_i = 1'b1;
        1:       s_wready_i = ((cyc % 2) == 0);
        default: s_wready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      chk("s_w", 64'(s_w_o), 64'(w_drv[win]));
      chk("wready", 64'(wready_obs), s_wready_i ? 64'(onehot(win)) : 64'd0);
      acc = s_wready_i;
      tick();
      if (acc) begin
        fwd++;
        if (w_drv[win].last) done = 1'b1;
        else w_drv[win] = mk_beat(fwd, lastpos);
      end
      if (abort_at > 0 && fwd == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_all_quiet("abort");
        w_drv[win] = '0;
        s_wready_i = 1'b0;
        model_reset();
        $display("[TB] txn m%0d aborted by reset after %0d beats", win, fwd);
        return;
      end
    end
    chk("beats_fwd", 64'(fwd), 64'(lastpos + 1));

    w_drv[win]      = '0;
    s_wready_i      = 1'b0;
    s_bvalid_i      = 1'b1;
    s_bresp_i       = bresp;
    bready_drv[los] = 1'b1;
    d = $urandom_range(0, 2);
    for (cyc = 0; cyc <= d; cyc++) begin
      bready_drv[win] = (cyc == d);
      #1;
      chk("bvalid", 64'(bvalid_obs), 64'(onehot(win)));
      chk("bresp_win", 64'(win == 1 ? bresp_obs[3:2] : bresp_obs[1:0]), 64'(bresp));
      chk("bresp_los", 64'(los == 1 ? bresp_obs[3:2] : bresp_obs[1:0]), 64'd0);
      chk("s_bready", 64'(s_bready_o), 64'(bready_drv[win]));
      chk("w_closed", 64'(wready_obs), 64'd0);
      tick();
    end
    s_bvalid_i = 1'b0;
    s_bresp_i  = 2'b00;
    bready_drv = 2'b00;
    #1;
    chk("busy_after_b", 64'(busy_o), 64'd0);
    chk("grant_after_b", 64'(grant_o), 64'd0);

    model_last_g = (win == 1);
    if (bresp != 2'b00 && model_cnt < CNT_MAX) model_cnt++;
    if (lastpos != pend_len[win]) model_len_err = 1'b1;
    chk("len_err", 64'(len_err_o), 64'(model_len_err));
    chk("resp_err_cnt", 64'(resp_err_cnt_o), 64'(model_cnt));
    $display("[TB] txn m%0d len=%0d beats=%0d bresp=%0d len_err=%0d cnt=%0d",
             win, pend_len[win], fwd, bresp, len_err_o, resp_err_cnt_o);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    aw_drv[0] = '0; aw_drv[1] = '0;
    w_drv[0]  = '0; w_drv[1]  = '0;
    bready_drv  = 2'b00;
    s_awready_i = 1'b0; s_wready_i = 1'b0;
    s_bvalid_i  = 1'b0; s_bresp_i  = 2'b00;
    model_reset();

    // reset values, including a request held during reset
    do_reset(3);
    #1;
    check_all_quiet("reset");
    rst = 1'b1;
    aw_drv[0].valid = 1'b1;
    tick();
    tick();
    chk("rst_hold_grant", 64'(grant_o), 64'd0);
    chk("rst_hold_s_aw", 64'(s_aw_o), 64'd0);
    aw_drv[0] = '0;
    rst = 1'b0;
    tick();

    // single long burst from m0
    post_aw(0, 239);
    serve_one(-1, 2'b00, 0, 0, 0);

    // simultaneous pairs: round-robin order
    do_reset(2);
    post_aw(0, $urandom_range(0, 7));
    post_aw(1, $urandom_range(0, 7));
    serve_one(-1, 2'b00, 0, 0, 0);
    serve_one(-1, 2'b00, 0, 0, 0);
    post_aw(0, $urandom_range(0, 7));
    post_aw(1, $urandom_range(0, 7));
    serve_one(-1, 2'b00, 0, 0, 0);
    serve_one(-1, 2'b00, 0, 0, 0);

    // slave backpressure on AW and W
    post_aw(1, 239);
    serve_one(-1, 2'b00, 5, 1, 0);

    // early WLAST, then stickiness across a clean transaction
    post_aw(0, 3);
    serve_one(1, 2'b00, 0, 0, 0);
    post_aw(1, 2);
    serve_one(-1, 2'b00, 0, 2, 0);

    // missing WLAST on the len-th beat
    do_reset(2);
    #1;
    chk("len_err_cleared", 64'(len_err_o), 64'd0);
    post_aw(1, 3);
    serve_one(4, 2'b00, 0, 0, 0);

    // random mix of requesters, lengths, backpressure and responses
    for (int t = 0; t < 20; t++) begin
      sel = $urandom_range(1, 3);
      if (sel[0]) post_aw(0, $urandom_range(0, 15));
      if (sel[1]) post_aw(1, $urandom_range(0, 15));
      while (pending[0] || pending[1])
        serve_one(-1, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 2), 0);
    end

    // error counter saturation
    do_reset(2);
    for (int t = 0; t < 300; t++) begin
      post_aw($urandom_range(0, 1), 0);
      serve_one(-1, 2'b10, 0, 0, 0);
    end
    chk("cnt_saturated", 64'(resp_err_cnt_o), 64'(CNT_MAX));

    // reset in the middle of a burst, then m0 must win the next tie
    post_aw(0, 239);
    serve_one(-1, 2'b00, 0, 0, 100);
    post_aw(0, 5);
    post_aw(1, 5);
    serve_one(-1, 2'b00, 0, 0, 0);
    serve_one(-1, 2'b00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
